// File: rtl/mc_controller.sv
// Multicycle ARM-subset main controller: instruction sequencer FSM,
// condition check against stored NZCV flags, and ALU decode.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic       alu_op;
    logic [3:0] cmd;
    logic       cmd_writes;
    logic       cmd_arith;
    logic       rd_pc;
    logic       n_f, z_f, c_f, v_f;

    assign cmd   = Funct[4:1];
    assign rd_pc = (Rd == 4'hF);
    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Only ADD/SUB/AND/ORR write back; CMP and unknown codes are NoWrite
    assign cmd_writes = (cmd == 4'b0100) || (cmd == 4'b0010) ||
                        (cmd == 4'b0000) || (cmd == 4'b1100);
    assign cmd_arith  = (cmd == 4'b0100) || (cmd == 4'b0010) ||
                        (cmd == 4'b1010);

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

    always_comb begin
        cond_ex = 1'b0;
        unique case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~(c_f & ~z_f);
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = ~(~z_f & (n_f == v_f));
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        alu_op    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (!cond_ex || Op == 2'b11) state_d = S_FETCH;
                else if (Op == 2'b01)        state_d = S_MEMADR;
                else if (Op == 2'b10)        state_d = S_BRANCH;
                else if (Funct[5])           state_d = S_EXECI;
                else                         state_d = S_EXECR;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                PCWrite   = rd_pc;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECR: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = cmd_writes;
                PCWrite  = cmd_writes & rd_pc;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset suppresses every write so an abandoned instruction has no effect
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    always_comb begin
        ALUControl = 2'b00;
        if (alu_op) begin
            unique case (cmd)
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                4'b1010: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
        end
    end

    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && Funct[0]) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (cmd_arith) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction latency and write-strobe
// signatures from a directed table, reset corner cases and a random stream.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Cond = 4'hE;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] ALUFlags = 4'd0;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;

    int total = 0;
    int bad = 0;
    logic [3:0] mflags;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] af;
        int         lat;
        int         reg_n;
        int         mem_n;
        int         pc_n;
        int         adr_n;
        int         alu;
    } vec_t;

    vec_t tbl[20];

    mc_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .ALUFlags(ALUFlags), .PCWrite(PCWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] cond, input logic [1:0] op,
                                input logic [5:0] funct, input logic [3:0] rd,
                                input logic [3:0] af, input int lat,
                                input int rg, input int mem, input int pc,
                                input int adr, input int alu);
        vec_t v;
        v.cond = cond; v.op = op; v.funct = funct; v.rd = rd; v.af = af;
        v.lat = lat; v.reg_n = rg; v.mem_n = mem; v.pc_n = pc;
        v.adr_n = adr; v.alu = alu;
        return v;
    endfunction

    // Instruction-level model: returns the expected signature, tracks flags
    function automatic vec_t predict(input logic [3:0] cond, input logic [1:0] op,
                                     input logic [5:0] funct, input logic [3:0] rd,
                                     input logic [3:0] af);
        logic n, z, c, v, base, ce, wr;
        int cmd;
        vec_t e;
        {n, z, c, v} = mflags;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        ce = cond[0] ? !base : base;
        cmd = int'(funct[4:1]);
        e = mk(cond, op, funct, rd, af, 2, 0, 0, 1, 0, 0);
        if (ce && op == 2'd2) begin
            e.lat = 3; e.pc_n = 2;
        end else if (ce && op == 2'd1) begin
            e.adr_n = 1;
            if (funct[0]) begin
                e.lat = 5; e.reg_n = 1; e.pc_n = (rd == 15) ? 2 : 1;
            end else begin
                e.lat = 4; e.mem_n = 1;
            end
        end else if (ce && op == 2'd0) begin
            wr = (cmd == 4) || (cmd == 2) || (cmd == 0) || (cmd == 12);
            e.lat = 4;
            e.reg_n = wr ? 1 : 0;
            e.pc_n = (wr && rd == 15) ? 2 : 1;
            case (cmd)
                2, 10: e.alu = 1;
                0: e.alu = 2;
                12: e.alu = 3;
                default: e.alu = 0;
            endcase
            if (funct[0]) begin
                mflags[3:2] = af[3:2];
                if (cmd == 4 || cmd == 2 || cmd == 10) mflags[1:0] = af[1:0];
            end
        end
        return e;
    endfunction

    // Entered just after a negedge with the DUT in FETCH; leaves the same way
    task automatic run_instr(input vec_t v, input string nm);
        int c = 0;
        int rg = 0, mem = 0, pc = 0, adr = 0, ir = 0;
        int alu2 = 0, alu_rest = 0, srcbad = 0;
        bit done = 0;
        Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd; ALUFlags = v.af;
        #2;
        while (!done && c < 12) begin
            if (c > 0 && IRWrite) begin
                done = 1;
            end else begin
                rg += int'(RegWrite);
                mem += int'(MemWrite);
                pc += int'(PCWrite);
                adr += int'(AdrSrc);
                ir += int'(IRWrite);
                if (c == 2) alu2 = int'(ALUControl);
                else alu_rest |= int'(ALUControl);
                if (ImmSrc !== Op || RegSrc !== {Op == 2'b01, Op == 2'b10})
                    srcbad = 1;
                c++;
                @(negedge clk);
                #2;
            end
        end
        chk({nm, " finish"}, int'(done), 1);
        chk({nm, " latency"}, c, v.lat);
        chk({nm, " regwrite"}, rg, v.reg_n);
        chk({nm, " memwrite"}, mem, v.mem_n);
        chk({nm, " pcwrite"}, pc, v.pc_n);
        chk({nm, " adrsrc"}, adr, v.adr_n);
        chk({nm, " irwrite"}, ir, 1);
        chk({nm, " alucontrol"}, (v.lat == 4 && v.op == 2'd0) ? alu2 : alu2 | 0, v.alu);
        chk({nm, " alucontrol idle"}, alu_rest, 0);
        chk({nm, " immsrc regsrc"}, srcbad, 0);
    endtask

    task automatic rst_mid(input vec_t v, input int at_cycle, input string nm);
        Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd; ALUFlags = v.af;
        for (int i = 0; i < at_cycle; i++) @(negedge clk);
        reset = 1'b1;
        #2;
        chk({nm, " strobes in reset"},
            int'({PCWrite, MemWrite, RegWrite, IRWrite}), 0);
        @(negedge clk);
        #2;
        chk({nm, " strobes reset fetch"},
            int'({PCWrite, MemWrite, RegWrite, IRWrite}), 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk({nm, " fetch after reset"}, int'({IRWrite, MemWrite}), 2);
    endtask

    initial begin
        vec_t e;
        tbl[0]  = mk(4'hE, 2'd0, 6'b001000, 4'd1, 4'hF, 4, 1, 0, 1, 0, 0);
        tbl[1]  = mk(4'h0, 2'd2, 6'b000000, 4'd0, 4'h0, 2, 0, 0, 1, 0, 0);
        tbl[2]  = mk(4'hE, 2'd0, 6'b000101, 4'd2, 4'h6, 4, 1, 0, 1, 0, 1);
        tbl[3]  = mk(4'h0, 2'd2, 6'b000000, 4'd0, 4'h0, 3, 0, 0, 2, 0, 0);
        tbl[4]  = mk(4'hE, 2'd1, 6'b000001, 4'hF, 4'h0, 5, 1, 0, 2, 1, 0);
        tbl[5]  = mk(4'hE, 2'd1, 6'b000000, 4'd3, 4'h0, 4, 0, 1, 1, 1, 0);
        tbl[6]  = mk(4'hF, 2'd0, 6'b001000, 4'd3, 4'h0, 2, 0, 0, 1, 0, 0);
        tbl[7]  = mk(4'hE, 2'd0, 6'b010101, 4'd2, 4'h8, 4, 0, 0, 1, 0, 1);
        tbl[8]  = mk(4'h4, 2'd2, 6'b000000, 4'd0, 4'h0, 3, 0, 0, 2, 0, 0);
        tbl[9]  = mk(4'h1, 2'd2, 6'b000000, 4'd0, 4'h0, 3, 0, 0, 2, 0, 0);
        tbl[10] = mk(4'h2, 2'd2, 6'b000000, 4'd0, 4'h0, 2, 0, 0, 1, 0, 0);
        tbl[11] = mk(4'hE, 2'd0, 6'b011000, 4'hF, 4'h7, 4, 1, 0, 2, 0, 3);
        tbl[12] = mk(4'hB, 2'd2, 6'b000000, 4'd0, 4'h0, 3, 0, 0, 2, 0, 0);
        tbl[13] = mk(4'hE, 2'd0, 6'b000001, 4'd4, 4'hF, 4, 1, 0, 1, 0, 2);
        tbl[14] = mk(4'h8, 2'd2, 6'b000000, 4'd0, 4'h0, 2, 0, 0, 1, 0, 0);
        tbl[15] = mk(4'h0, 2'd2, 6'b000000, 4'd0, 4'h0, 3, 0, 0, 2, 0, 0);
        tbl[16] = mk(4'hE, 2'd3, 6'b000000, 4'd0, 4'h0, 2, 0, 0, 1, 0, 0);
        tbl[17] = mk(4'hE, 2'd0, 6'b000011, 4'd5, 4'h3, 4, 0, 0, 1, 0, 0);
        tbl[18] = mk(4'h6, 2'd2, 6'b000000, 4'd0, 4'h0, 2, 0, 0, 1, 0, 0);
        tbl[19] = mk(4'h3, 2'd2, 6'b000000, 4'd0, 4'h0, 3, 0, 0, 2, 0, 0);

        repeat (3) @(negedge clk);
        #2;
        chk("reset strobes", int'({PCWrite, MemWrite, RegWrite, IRWrite}), 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("first fetch", int'({PCWrite, IRWrite}), 3);

        for (int i = 0; i < 20; i++)
            run_instr(tbl[i], $sformatf("vec%0d", i));

        run_instr(mk(4'hE, 2'd0, 6'b000101, 4'd1, 4'h4, 4, 1, 0, 1, 0, 1), "subs z");
        rst_mid(mk(4'hE, 2'd0, 6'b001001, 4'd1, 4'h4, 0, 0, 0, 0, 0, 0), 2, "rst exec");
        run_instr(mk(4'h0, 2'd2, 6'b000000, 4'd0, 4'h0, 2, 0, 0, 1, 0, 0), "beq cleared");
        run_instr(mk(4'hE, 2'd1, 6'b000000, 4'd3, 4'h0, 4, 0, 1, 1, 1, 0), "str 1");
        rst_mid(mk(4'hE, 2'd1, 6'b000000, 4'd3, 4'h0, 0, 0, 0, 0, 0, 0), 2, "rst memadr");
        run_instr(mk(4'h1, 2'd2, 6'b000000, 4'd0, 4'h0, 3, 0, 0, 2, 0, 0), "bne cleared");

        mflags = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            logic [3:0] cd, rd, af;
            logic [1:0] op;
            logic [5:0] fn;
            cd = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom_range(0, 63));
            rd = 4'($urandom_range(0, 15));
            af = 4'($urandom_range(0, 15));
            e = predict(cd, op, fn, rd, af);
            run_instr(e, $sformatf("rnd%0d c%h o%0d f%b", i, cd, op, fn));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Cond  in  4  instruction condition field Instr[31:28].
REQ-005 Op  in  2  instruction class Instr[27:26].
REQ-006 Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L.
REQ-007 Rd  in  4  destination register Instr[15:12].
REQ-008 ALUFlags  in  4  {N,Z,C,V} from ALU, valid during EXECR/EXECI.
REQ-009 PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  datapath write enables.
REQ-010 AdrSrc, ALUSrcA  out  1 each  memory address / ALU A mux selects.
REQ-011 ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc  out  2 each  datapath mux and ALU selects.

Function
REQ-012 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-013 Transitions SHALL be: FETCH->DECODE; MEMADR->MEMRD if Funct[0]=1, else MEMWR; MEMRD->MEMWB; EXECR, EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-014 DECODE SHALL go to FETCH if CondEx=0 or Op=11; otherwise Op=01->MEMADR, Op=10->BRANCH, Op=00 with Funct[5]=0->EXECR, Op=00 with Funct[5]=1->EXECI.
REQ-015 CondEx SHALL be combinational from Cond and stored flags {N,Z,C,V}: 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V, 1000 C&!Z, 1001 !(C&!Z), 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 !(!Z&(N==V)), 1110 1, 1111 0 (never X).
REQ-016 State outputs (unlisted=0): FETCH IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1; DECODE ALUSrcA=1, ALUSrcB=10, ResultSrc=10; MEMADR ALUSrcB=01; MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1; MEMWR AdrSrc=1, MemWrite=1; EXECR ALUSrcB=00, ALUOp=1; EXECI ALUSrcB=01, ALUOp=1; ALUWB RegWrite=1; BRANCH ALUSrcB=01, ResultSrc=10, PCWrite=1.
REQ-017 ALUControl SHALL be 00 when ALUOp=0; when ALUOp=1, Funct[4:1]: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11, 1010 CMP->01, any other->00.
REQ-018 In ALUWB, RegWrite SHALL be 0 for CMP (NoWrite) and for undefined cmd codes.
REQ-019 In MEMWB/ALUWB with Rd=1111, RegWrite=1 and PCWrite=1 SHALL both assert (PC writeback).
REQ-020 Flags[3:2] (N,Z) SHALL load ALUFlags[3:2] at the end of EXECR/EXECI when Funct[0]=1.
REQ-021 Flags[1:0] (C,V) SHALL load ALUFlags[1:0] at the end of EXECR/EXECI when Funct[0]=1 and cmd is ADD, SUB or CMP.
REQ-022 Flags SHALL hold in all other states.
REQ-023 ImmSrc SHALL equal Op, combinationally, in every state.
REQ-024 RegSrc[0] SHALL be (Op==10) and RegSrc[1] SHALL be (Op==01), combinationally, in every state.
REQ-025 Instruction latencies SHALL be: data-processing 4 cycles, LDR 5, STR 4, B 3, failed condition or Op=11 2.
REQ-026 A flag update in EXECR/EXECI SHALL be visible to CondEx at the next instruction's DECODE.

Reset
REQ-027 While reset=1, state SHALL be forced to FETCH, Flags SHALL be 0000, and PCWrite, MemWrite, RegWrite and IRWrite SHALL be 0.
REQ-028 In the first cycle after reset deasserts, the block SHALL be in FETCH.
REQ-029 Reset asserted mid-instruction SHALL abandon that instruction with no further writes and no flag update.

Verification
REQ-030 Reset, then Op=00, Funct=001000 (ADD imm), Cond=1110 -> FETCH, DECODE, EXECI, ALUWB; RegWrite=1 only in ALUWB; ALUControl=00; Flags unchanged.
REQ-031 SUBS reg (Funct=000101) with ALUFlags=0110 -> Flags=0110 after EXECR; following BEQ (Cond=0000, Op=10) -> BRANCH with PCWrite=1, 3 cycles.
REQ-032 Flags Z=0; BEQ -> DECODE returns to FETCH; no PCWrite in DECODE; 2 cycles.
REQ-033 LDR (Op=01, Funct[0]=1, Rd=1111) -> 5 cycles; MEMWB asserts RegWrite=1 and PCWrite=1.
REQ-034 STR (Funct[0]=0) -> MemWrite=1 only in MEMWR, AdrSrc=1; reset asserted in MEMADR of a second STR -> no MemWrite; FETCH on the next cycle.
REQ-035 Cond=1111 -> skipped; CMP (Funct=010101) -> ALUWB with RegWrite=0 and flags updated.
